// File: rtl/multichannel_mean_remover.sv
// Per-channel moving-average DC removal for a channel-interleaved sample stream.
// Each channel owns an M-sample window in a shared RAM, a running window sum and a
// fill counter. Every accepted sample is written into its window, and the block then
// emits the sample minus the window mean (saturated), the raw sample, or the mean.
// One sample is processed every 5 cycles; there is no skid buffer.
module multichannel_mean_remover #(
    parameter int unsigned N_CH   = 8,
    parameter int unsigned LOG2_M = 5,
    parameter int unsigned Q_IN   = 24,
    parameter int unsigned CH_W   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic [1:0]      mode,
    input  logic [Q_IN-1:0] data_in,
    input  logic [CH_W-1:0] data_in_ch,
    input  logic            data_in_valid,
    output logic            data_in_ready,
    output logic [Q_IN-1:0] data_out,
    output logic [CH_W-1:0] data_out_ch,
    output logic            data_out_valid,
    output logic            data_out_settled
);

    localparam int unsigned M        = 2 ** LOG2_M;
    localparam int unsigned AW       = CH_W + LOG2_M;
    // Storage is sized to the full address space; words of channels >= N_CH are
    // never addressed, so the sweep only covers the N_CH*M live words.
    localparam int unsigned Depth    = 2 ** AW;
    localparam int unsigned NumSlots = 2 ** CH_W;
    localparam int unsigned AccW     = Q_IN + LOG2_M;
    localparam int unsigned FillW    = LOG2_M + 1;
    localparam int unsigned ChCmpW   = CH_W + 1;

    localparam logic [AW-1:0]     LastWord = AW'(N_CH * M - 1);
    localparam logic [FillW-1:0]  FillFull = FillW'(M);
    localparam logic [FillW-1:0]  FillOne  = FillW'(1);
    localparam logic [LOG2_M-1:0] IdxOne   = LOG2_M'(1);
    localparam logic [ChCmpW-1:0] NumCh    = ChCmpW'(N_CH);
    localparam logic [Q_IN-1:0]   MaxPos   = {1'b0, {(Q_IN - 1){1'b1}}};
    localparam logic [Q_IN-1:0]   MinNeg   = {1'b1, {(Q_IN - 1){1'b0}}};

    typedef enum logic [2:0] {
        StClean,
        StIdle,
        StRead,
        StUpdate,
        StMean,
        StOut,
        StDrop
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0]     clean_cnt_q;
    logic [Q_IN-1:0]   data_q;
    logic [CH_W-1:0]   ch_q;
    logic [1:0]        mode_q;
    logic [Q_IN-1:0]   old_q;
    logic [Q_IN-1:0]   mean_q;

    logic [AccW-1:0]   acc_q  [NumSlots];
    logic [LOG2_M-1:0] idx_q  [NumSlots];
    logic [FillW-1:0]  fill_q [NumSlots];
    logic [Q_IN-1:0]   mem    [Depth];

    logic              accept;
    logic              ch_ok;
    logic [AW-1:0]     addr;
    logic [AccW-1:0]   acc_upd;
    logic [Q_IN:0]     diff;
    logic [Q_IN-1:0]   sat_diff;
    logic [Q_IN-1:0]   result;
    logic              settled_now;

    assign data_in_ready = (state_q == StIdle);
    // clear outranks a same-cycle accept, so the sample is simply not taken
    assign accept        = (state_q == StIdle) && data_in_valid && !clear;
    assign ch_ok         = ({1'b0, data_in_ch} < NumCh);
    assign addr          = {ch_q, idx_q[ch_q]};
    assign settled_now   = (fill_q[ch_q] == FillFull);

    // Window sum after replacing the oldest sample with the new one.
    assign acc_upd = acc_q[ch_q]
                   + {{LOG2_M{data_q[Q_IN-1]}}, data_q}
                   - {{LOG2_M{old_q[Q_IN-1]}}, old_q};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StClean;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear forces a fresh sweep from any state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClean: begin
                if (clean_cnt_q == LastWord) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (data_in_valid) begin
                    state_d = ch_ok ? StRead : StDrop;
                end
            end
            StRead:   state_d = StUpdate;
            StUpdate: state_d = StMean;
            StMean:   state_d = StOut;
            StOut:    state_d = StIdle;
            StDrop:   state_d = StIdle;
            default:  state_d = StClean;
        endcase
        if (clear) begin
            state_d = StClean;
        end
    end

    // Sweep address; restarts at zero on every entry into the sweep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clean_cnt_q <= '0;
        end else if (clear || state_q != StClean) begin
            clean_cnt_q <= '0;
        end else begin
            clean_cnt_q <= clean_cnt_q + AW'(1);
        end
    end

    // Capture the sample, its channel and the mode at acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            ch_q   <= '0;
            mode_q <= '0;
        end else if (accept) begin
            data_q <= data_in;
            ch_q   <= data_in_ch;
            mode_q <= mode;
        end
    end

    // Sample RAM: zeroed by the sweep, one write per processed sample, one read of
    // the sample about to leave the window.
    always_ff @(posedge clock) begin
        if (state_q == StClean) begin
            mem[clean_cnt_q] <= '0;
        end else if (state_q == StUpdate && !clear) begin
            mem[addr] <= data_q;
        end
        if (state_q == StRead) begin
            old_q <= mem[addr];
        end
    end

    // Per-channel window bookkeeping: sum, write index and saturating fill count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NumSlots; i++) begin
                acc_q[i]  <= '0;
                idx_q[i]  <= '0;
                fill_q[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < NumSlots; i++) begin
                acc_q[i]  <= '0;
                idx_q[i]  <= '0;
                fill_q[i] <= '0;
            end
        end else if (state_q == StUpdate) begin
            acc_q[ch_q] <= acc_upd;
            idx_q[ch_q] <= idx_q[ch_q] + IdxOne;
            if (fill_q[ch_q] != FillFull) begin
                fill_q[ch_q] <= fill_q[ch_q] + FillOne;
            end
        end
    end

    // Window mean: dropping the low LOG2_M bits is an arithmetic shift (floor).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mean_q <= '0;
        end else if (state_q == StMean) begin
            mean_q <= acc_q[ch_q][AccW-1:LOG2_M];
        end
    end

    // Result selection, with the difference formed one bit wider and clamped.
    always_comb begin
        diff     = {data_q[Q_IN-1], data_q} - {mean_q[Q_IN-1], mean_q};
        sat_diff = diff[Q_IN-1:0];
        if (diff[Q_IN] != diff[Q_IN-1]) begin
            sat_diff = diff[Q_IN] ? MinNeg : MaxPos;
        end
        result = sat_diff;
        unique case (mode_q)
            2'd1:    result = data_q;
            2'd2:    result = mean_q;
            default: result = sat_diff;
        endcase
    end

    // Output register: results are held, valid pulses once; clear aborts the result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out         <= '0;
            data_out_ch      <= '0;
            data_out_valid   <= 1'b0;
            data_out_settled <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            if (state_q == StOut && !clear) begin
                data_out_valid   <= 1'b1;
                data_out         <= result;
                data_out_ch      <= ch_q;
                data_out_settled <= settled_now;
            end
        end
    end

endmodule

// File: tb/tb_multichannel_mean_remover.sv
// Directed bench for multichannel_mean_remover (N_CH=2, M=4, Q_IN=16), plus a
// single-channel instance used to exercise the out-of-range channel drop.
module tb_multichannel_mean_remover;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] data_in = '0;
    logic [0:0]  data_in_ch = '0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [15:0] data_out;
    logic [0:0]  data_out_ch;
    logic        data_out_valid;
    logic        data_out_settled;

    logic [1:0]  b_mode = 2'd0;
    logic [15:0] b_data_in = '0;
    logic [0:0]  b_ch = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] b_out;
    logic [0:0]  b_out_ch;
    logic        b_out_valid;
    logic        b_out_settled;

    int checks = 0;
    int errors = 0;

    multichannel_mean_remover #(
        .N_CH   (2),
        .LOG2_M (2),
        .Q_IN   (16),
        .CH_W   (1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .clear            (clear),
        .mode             (mode),
        .data_in          (data_in),
        .data_in_ch       (data_in_ch),
        .data_in_valid    (data_in_valid),
        .data_in_ready    (data_in_ready),
        .data_out         (data_out),
        .data_out_ch      (data_out_ch),
        .data_out_valid   (data_out_valid),
        .data_out_settled (data_out_settled)
    );

    multichannel_mean_remover #(
        .N_CH   (1),
        .LOG2_M (2),
        .Q_IN   (16),
        .CH_W   (1)
    ) dut1 (
        .clock            (clock),
        .reset            (reset),
        .clear            (clear),
        .mode             (b_mode),
        .data_in          (b_data_in),
        .data_in_ch       (b_ch),
        .data_in_valid    (b_valid),
        .data_in_ready    (b_ready),
        .data_out         (b_out),
        .data_out_ch      (b_out_ch),
        .data_out_valid   (b_out_valid),
        .data_out_settled (b_out_settled)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) until the main DUT is ready.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (data_in_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, ".ready"}, 32'(data_in_ready), 1);
    endtask

    // One sample through the main DUT; checks latency, result, channel and settled.
    task automatic send(input string tag, input int ch, input int d, input int md,
                        input int exp_out, input int exp_set);
        int lat;
        @(negedge clock);
        wait_ready(tag);
        data_in       = 16'(d);
        data_in_ch    = 1'(ch);
        mode          = 2'(md);
        data_in_valid = 1'b1;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        lat = 0;
        while (lat < 12) begin
            @(negedge clock);
            lat++;
            if (lat == 1) check({tag, ".ready_fall"}, 32'(data_in_ready), 0);
            if (data_out_valid === 1'b1) break;
        end
        // accept at edge T, valid visible after edge T+4: 5th negedge after T
        check({tag, ".lat"}, lat, 5);
        check({tag, ".data"}, $signed(data_out), exp_out);
        check({tag, ".ch"}, 32'(data_out_ch), ch);
        check({tag, ".settled"}, 32'(data_out_settled), exp_set);
        check({tag, ".ready_rise"}, 32'(data_in_ready), 1);
        @(negedge clock);
        check({tag, ".pulse"}, 32'(data_out_valid), 0);
    endtask

    task automatic pulse_clear;
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        int lat;

        // Reset values
        #2;
        check("rst.data_out", $signed(data_out), 0);
        check("rst.data_out_ch", 32'(data_out_ch), 0);
        check("rst.valid", 32'(data_out_valid), 0);
        check("rst.settled", 32'(data_out_settled), 0);
        check("rst.ready", 32'(data_in_ready), 0);

        // Release just after an edge; the following cycle is the first clean cycle.
        // 8 clean cycles sampled low (n=1..8), ready first seen high at n=9.
        @(posedge clock);
        #1;
        reset = 1'b1;
        n = 0;
        seen = 0;
        while (n < 30) begin
            @(negedge clock);
            n++;
            if (data_out_valid === 1'b1) seen = 1;
            if (data_in_ready === 1'b1) break;
        end
        check("rst.ready_cycles", n, 9);
        check("rst.no_valid", seen, 0);
        check("rst.data_after", $signed(data_out), 0);

        // Mode 0, ch0 fed 100 four times
        send("m0_1", 0, 100, 0, 75, 0);
        send("m0_2", 0, 100, 0, 50, 0);
        send("m0_3", 0, 100, 0, 25, 0);
        send("m0_4", 0, 100, 0, 0, 1);

        // Interleaved channels
        pulse_clear();
        send("il_a0", 0, 100, 0, 75, 0);
        send("il_b0", 1, -3, 0, -2, 0);
        send("il_a1", 0, 100, 0, 50, 0);
        send("il_b1", 1, -3, 0, -1, 0);
        send("il_a2", 0, 100, 0, 25, 0);
        send("il_b2", 1, -3, 0, 0, 0);
        send("il_a3", 0, 100, 0, 0, 1);
        send("il_b3", 1, -3, 0, 0, 1);

        // Positive saturation: means -8192, -16384, -24576, -32768, then -16385
        pulse_clear();
        send("sp_1", 0, -32768, 0, -24576, 0);
        send("sp_2", 0, -32768, 0, -16384, 0);
        send("sp_3", 0, -32768, 0, -8192, 0);
        send("sp_4", 0, -32768, 0, 0, 1);
        send("sp_sat", 0, 32767, 0, 32767, 1);

        // Negative saturation: means 8191, 16383, 24575, 32767, then 16383
        pulse_clear();
        send("sn_1", 0, 32767, 0, 24576, 0);
        send("sn_2", 0, 32767, 0, 16384, 0);
        send("sn_3", 0, 32767, 0, 8192, 0);
        send("sn_4", 0, 32767, 0, 0, 1);
        send("sn_sat", 0, -32768, 0, -32768, 1);

        // Modes: bypass, mean, and mode 3 behaving like mode 0
        pulse_clear();
        send("md_f1", 0, 100, 0, 75, 0);
        send("md_f2", 0, 100, 0, 50, 0);
        send("md_f3", 0, 100, 0, 25, 0);
        send("md_f4", 0, 100, 0, 0, 1);
        send("md_byp", 0, 40, 1, 40, 1);
        send("md_mean", 0, 40, 2, 70, 1);
        // window 40,40,100,100 -> mean 70 -> 100-70
        send("md_m3", 0, 100, 3, 30, 1);

        // Clear while the sample sits in READ: no output, fresh 8-cycle sweep
        @(negedge clock);
        wait_ready("clr");
        data_in       = 16'd500;
        data_in_ch    = 1'b0;
        mode          = 2'd0;
        data_in_valid = 1'b1;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        clear         = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        n = 0;
        seen = 0;
        while (n < 30) begin
            @(negedge clock);
            n++;
            if (data_out_valid === 1'b1) seen = 1;
            if (data_in_ready === 1'b1) break;
        end
        check("clr.ready_cycles", n, 9);
        check("clr.no_valid", seen, 0);
        send("clr_after", 0, 100, 0, 75, 0);

        // Out-of-range channel on the single-channel instance
        @(negedge clock);
        n = 0;
        while (b_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("drop.ready_pre", 32'(b_ready), 1);
        b_data_in = 16'd1234;
        b_ch      = 1'b1;
        b_mode    = 2'd0;
        b_valid   = 1'b1;
        @(posedge clock);
        #1;
        b_valid = 1'b0;
        @(negedge clock);
        check("drop.ready_c1", 32'(b_ready), 0);
        seen = (b_out_valid === 1'b1) ? 1 : 0;
        @(negedge clock);
        check("drop.ready_c2", 32'(b_ready), 1);
        for (int i = 0; i < 6; i++) begin
            if (b_out_valid === 1'b1) seen = 1;
            @(negedge clock);
        end
        check("drop.no_valid", seen, 0);

        // Channel 0 of that instance is untouched by the dropped sample
        b_data_in = 16'd100;
        b_ch      = 1'b0;
        b_valid   = 1'b1;
        @(posedge clock);
        #1;
        b_valid = 1'b0;
        lat = 0;
        while (lat < 12) begin
            @(negedge clock);
            lat++;
            if (b_out_valid === 1'b1) break;
        end
        check("drop.next_lat", lat, 5);
        check("drop.next_data", $signed(b_out), 75);
        check("drop.next_settled", 32'(b_out_settled), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multichannel_mean_remover.md
# multichannel_mean_remover

Per-channel moving-average DC removal for the channel-interleaved ADC sample stream, placed between the ADS1299 deframer and the SSVEP lock-in/filter chain. Keeps an independent M-sample window, accumulator and fill counter for each of N_CH channels in one shared sample RAM. Outputs each sample minus its channel's current window mean, with saturation. Supports bypass and mean-output modes, a synchronous clear, and a per-channel settled flag.

## Interface
- N_CH, 8, number of channels (1..16)
- LOG2_M, 5, log2 of window length; M = 2^LOG2_M (1..10)
- Q_IN, 24, sample width, signed two's complement
- CH_W, 4, channel index width; must satisfy 2^CH_W >= N_CH
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear pulse: restart clean sweep
- mode  in  2  0 = remove mean, 1 = bypass, 2 = output mean, 3 = same as 0; sampled at input acceptance
- data_in  in  Q_IN  input sample, signed
- data_in_ch  in  CH_W  channel index of data_in
- data_in_valid  in  1  input qualifier
- data_in_ready  out  1  high only in IDLE
- data_out  out  Q_IN  result, signed, saturated
- data_out_ch  out  CH_W  channel of data_out
- data_out_valid  out  1  one-cycle pulse per result
- data_out_settled  out  1  channel window has received at least M samples since the last clean

## Operation
- Storage: RAM of N_CH*M x Q_IN, addressed {ch, idx[ch]}. Per channel: idx (LOG2_M bits), acc (Q_IN+LOG2_M bits, signed), fill counter (saturates at M).
- FSM states:
  - CLEAN: zeroes one RAM word per cycle over N_CH*M cycles, then goes to IDLE. Acc, idx and fill are cleared on entry.
  - IDLE: data_in_ready=1. On valid&&ready, latch data, ch and mode, then go to READ.
  - READ: old = mem[ch][idx[ch]].
  - UPDATE: mem[ch][idx[ch]] <= data; acc[ch] <= acc[ch] + data - old; idx[ch] wraps M-1 -> 0; fill[ch] increments.
  - MEAN: mean = acc[ch] >>> LOG2_M (arithmetic shift, floor toward -inf).
  - OUT: drive the result and pulse data_out_valid, then return to IDLE.
- Result by mode:
  - mode 0: sat(data - mean), computed at Q_IN+1 bits and clamped to [-2^(Q_IN-1), 2^(Q_IN-1)-1].
  - mode 1: data unchanged.
  - mode 2: mean.
  - The window is updated in all modes.
- data_out_settled is fill[ch]==M, evaluated after the update, so it is high on the M-th sample.
- Channel index >= N_CH: the sample is accepted (ready handshake completes), dropped with no output, and no state changes; the FSM returns to IDLE after one cycle.
- clear is honoured in any state. It aborts an in-flight sample (no output for it) and enters CLEAN. If clear is asserted in the same cycle as an accept, clear wins and the sample is dropped.
- Reset mid-operation: immediate return to CLEAN; the cycle after reset deassertion is the first clean cycle.

## Timing
- Reset values: data_out=0, data_out_ch=0, data_out_valid=0, data_out_settled=0, data_in_ready=0; state=CLEAN.
- After reset or clear: data_in_ready stays low for N_CH*M cycles, then goes high.
- Latency: accept at edge T; data_out_valid is high for exactly the cycle after edge T+4. data_out, data_out_ch and data_out_settled are held until the next result.
- Throughput: one sample per 5 cycles. data_in_ready falls the cycle after accept and rises together with data_out_valid.
- The upstream block holds data_in, data_in_ch and data_in_valid until ready is seen; no skid buffer.
- data_out_valid is never high during CLEAN.

## Test plan
Bench parameters: N_CH=2, LOG2_M=2, Q_IN=16, CH_W=1.
- Reset release: data_in_ready stays low 8 cycles then goes high; all outputs read 0; no valid pulse.
- Mode 0, ch0 fed 100 four times: outputs 75, 50, 25, 0; settled is 0, 0, 0, 1; each valid arrives 5 cycles after its accept.
- Interleaved channels: ch0=100 and ch1=-3 alternating. ch1 outputs are -2 (floor: -3>>>2=-1), then -1 (mean -6>>>2=-2), 0, 0. ch0 outputs are unaffected (75, 50, 25, 0).
- Saturation: fill ch0 with four samples of -32768, then send 32767. acc=-65537, mean=-16385, unsaturated result 49152, so data_out=32767. The reverse case (fill with 32767, then send -32768) gives data_out=-32768.
- Modes: after ch0 is filled with 100s, send 40 in mode 1 and get 40; then send 40 in mode 2 and get the mean (100+100+40+40)>>>2=70.
- Clear and drop: asserting clear during READ gives no output and ready low for 8 cycles; the next ch0=100 then yields 75 with settled=0. A sample on ch index 1 with N_CH=1 produces no valid pulse and ready returns after 2 cycles.
